// File: rtl/tb_assert_pkg.sv
// Shared types for the assertion monitor: report status codes, report FSM
// states and the channel-index width helper.
package tb_assert_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_FAIL  = 2'd2,
    ST_NOCHK = 2'd3
  } rpt_status_e;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_SNAP = 2'd1,
    RS_HOLD = 2'd2
  } rpt_state_e;

  // A single channel still needs a 1-bit index port.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tb_popcount.sv
// Combinational population count of an N-bit vector.
module tb_popcount #(
  parameter int N = 4
) (
  input  logic [N-1:0]             vec,
  output logic [$clog2(N+1)-1:0]   cnt
);

  localparam int W = $clog2(N + 1);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + W'(vec[i]);
  end

endmodule

// File: rtl/tb_assert_mon.sv
// Multi-channel check monitor: saturating total/pass/fail counters, sticky
// first-failure capture, die-on-fail halt and a level-handshake report snapshot.
module tb_assert_mon
  import tb_assert_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [NCH-1:0]           chk_valid,
  input  logic [NCH-1:0]           chk_pass,
  input  logic                     die_en,
  input  logic                     rpt_req,
  output logic                     rpt_ack,
  output logic [1:0]               rpt_status,
  output logic [CNT_W-1:0]         rpt_tot,
  output logic [CNT_W-1:0]         rpt_pass,
  output logic [CNT_W-1:0]         rpt_fail,
  output logic [NCH-1:0]           fail_mask,
  output logic [ch_w(NCH)-1:0]     first_fail_ch,
  output logic [TS_W-1:0]          first_fail_ts,
  output logic                     halt
);

  localparam int CH_W = ch_w(NCH);
  localparam int PC_W = $clog2(NCH + 1);
  localparam int SW   = CNT_W + PC_W;

  logic [NCH-1:0]   pass_vec, fail_vec;
  logic [PC_W-1:0]  pass_cnt, fail_cnt, tot_inc;
  logic [CNT_W-1:0] tot_q, pass_q, fail_q;
  logic [TS_W-1:0]  ts_q;
  logic [CH_W-1:0]  ff_idx;

  rpt_state_e  state, state_nxt;
  rpt_status_e snap_status;
  logic        snap_ld;

  assign pass_vec = chk_valid & chk_pass;
  assign fail_vec = chk_valid & ~chk_pass;

  tb_popcount #(.N(NCH)) u_pc_pass (.vec(pass_vec), .cnt(pass_cnt));
  tb_popcount #(.N(NCH)) u_pc_fail (.vec(fail_vec), .cnt(fail_cnt));

  // Sum of two disjoint popcounts never exceeds NCH, so PC_W bits suffice.
  assign tot_inc = pass_cnt + fail_cnt;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return (s > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    ff_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) if (fail_vec[i]) ff_idx = CH_W'(i);
  end

  // Free-running timestamp, deliberately immune to clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tot_q         <= '0;
      pass_q        <= '0;
      fail_q        <= '0;
      fail_mask     <= '0;
      first_fail_ch <= '0;
      first_fail_ts <= '0;
      halt          <= 1'b0;
    end else if (clr) begin
      tot_q         <= '0;
      pass_q        <= '0;
      fail_q        <= '0;
      fail_mask     <= '0;
      first_fail_ch <= '0;
      first_fail_ts <= '0;
      halt          <= 1'b0;
    end else begin
      tot_q     <= sat_add(tot_q, tot_inc);
      pass_q    <= sat_add(pass_q, pass_cnt);
      fail_q    <= sat_add(fail_q, fail_cnt);
      fail_mask <= fail_mask | fail_vec;
      // Saturating fail count never returns to zero, so this latches once.
      if (fail_q == '0 && |fail_vec) begin
        first_fail_ch <= ff_idx;
        first_fail_ts <= ts_q;
      end
      if (die_en && |fail_vec) halt <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    snap_ld   = 1'b0;
    case (state)
      RS_IDLE: if (rpt_req) state_nxt = RS_SNAP;
      RS_SNAP: begin
        snap_ld   = 1'b1;
        state_nxt = RS_HOLD;
      end
      RS_HOLD: if (!rpt_req) state_nxt = RS_IDLE;
      default: state_nxt = RS_IDLE;
    endcase
  end

  // Snapshot takes the pre-edge live values, so checks in the SNAP cycle miss it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_tot     <= '0;
      rpt_pass    <= '0;
      rpt_fail    <= '0;
      snap_status <= ST_IDLE;
    end else if (snap_ld) begin
      rpt_tot     <= tot_q;
      rpt_pass    <= pass_q;
      rpt_fail    <= fail_q;
      snap_status <= (fail_q != '0) ? ST_FAIL :
                     (tot_q == '0)  ? ST_NOCHK : ST_PASS;
    end
  end

  assign rpt_ack    = (state == RS_HOLD);
  assign rpt_status = rpt_ack ? snap_status : ST_IDLE;

endmodule

// File: tb/tb_tb_assert_mon.sv
// Directed bench for tb_assert_mon: a wide-counter instance and a 4-bit
// counter instance share all stimulus; expected values are hand-computed.
module tb_tb_assert_mon;

  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst_n, clr, die_en, rpt_req;
  logic [NCH-1:0] chk_valid, chk_pass;

  logic        rpt_ack, halt;
  logic [1:0]  rpt_status;
  logic [15:0] rpt_tot, rpt_pass, rpt_fail;
  logic [NCH-1:0] fail_mask;
  logic [1:0]  first_fail_ch;
  logic [31:0] first_fail_ts;

  logic        s_rpt_ack, s_halt;
  logic [1:0]  s_rpt_status;
  logic [3:0]  s_rpt_tot, s_rpt_pass, s_rpt_fail;
  logic [NCH-1:0] s_fail_mask;
  logic [1:0]  s_first_fail_ch;
  logic [31:0] s_first_fail_ts;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tb_assert_mon #(.NCH(NCH), .CNT_W(16), .TS_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .chk_valid(chk_valid), .chk_pass(chk_pass),
    .die_en(die_en), .rpt_req(rpt_req), .rpt_ack(rpt_ack), .rpt_status(rpt_status),
    .rpt_tot(rpt_tot), .rpt_pass(rpt_pass), .rpt_fail(rpt_fail), .fail_mask(fail_mask),
    .first_fail_ch(first_fail_ch), .first_fail_ts(first_fail_ts), .halt(halt)
  );

  tb_assert_mon #(.NCH(NCH), .CNT_W(4), .TS_W(32)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .chk_valid(chk_valid), .chk_pass(chk_pass),
    .die_en(die_en), .rpt_req(rpt_req), .rpt_ack(s_rpt_ack), .rpt_status(s_rpt_status),
    .rpt_tot(s_rpt_tot), .rpt_pass(s_rpt_pass), .rpt_fail(s_rpt_fail), .fail_mask(s_fail_mask),
    .first_fail_ch(s_first_fail_ch), .first_fail_ts(s_first_fail_ts), .halt(s_halt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; die_en = 1'b0; rpt_req = 1'b0;
    chk_valid = '0; chk_pass = '0;
    #12;
    chk("rst_ack",    64'(rpt_ack), 64'd0);
    chk("rst_status", 64'(rpt_status), 64'd0);
    chk("rst_halt",   64'(halt), 64'd0);
    chk("rst_mask",   64'(fail_mask), 64'd0);
    chk("rst_ffts",   64'(first_fail_ts), 64'd0);
    chk("rst_tot",    64'(rpt_tot), 64'd0);

    // Release at a negedge: after k further posedges the timestamp equals k.
    @(negedge clk);
    rst_n = 1'b1;
    steps(7);
    chk_valid = 4'b1010; chk_pass = 4'b0000;
    step();
    chk_valid = '0;
    chk("ff_mask", 64'(fail_mask), 64'b1010);
    chk("ff_ch",   64'(first_fail_ch), 64'd1);
    chk("ff_ts",   64'(first_fail_ts), 64'd7);

    rpt_req = 1'b1;
    steps(2);
    chk("ff_ack",    64'(rpt_ack), 64'd1);
    chk("ff_status", 64'(rpt_status), 64'd2);
    chk("ff_fail",   64'(rpt_fail), 64'd2);
    chk("ff_tot",    64'(rpt_tot), 64'd2);
    rpt_req = 1'b0;
    step();
    chk("ff_ack_drop", 64'(rpt_ack), 64'd0);
    chk("ff_status_idle", 64'(rpt_status), 64'd0);

    chk_valid = 4'b0001; chk_pass = 4'b0000;
    step();
    chk_valid = '0;
    chk("ff2_ch",   64'(first_fail_ch), 64'd1);
    chk("ff2_ts",   64'(first_fail_ts), 64'd7);
    chk("ff2_mask", 64'(fail_mask), 64'b1011);

    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_mask", 64'(fail_mask), 64'd0);
    chk("clr_ffts", 64'(first_fail_ts), 64'd0);

    // 10 cycles of all-pass, then failures arriving in the SNAP cycle.
    chk_valid = 4'b1111; chk_pass = 4'b1111;
    steps(10);
    chk_valid = '0;
    rpt_req = 1'b1;
    step();
    chk_valid = 4'b1111; chk_pass = 4'b0000;
    step();
    chk_valid = '0;
    chk("p40_ack",    64'(rpt_ack), 64'd1);
    chk("p40_status", 64'(rpt_status), 64'd1);
    chk("p40_tot",    64'(rpt_tot), 64'd40);
    chk("p40_pass",   64'(rpt_pass), 64'd40);
    chk("p40_fail",   64'(rpt_fail), 64'd0);
    chk("snapcyc_mask", 64'(fail_mask), 64'b1111);
    clr = 1'b1; step(); clr = 1'b0;
    chk("hold_clr_ack", 64'(rpt_ack), 64'd1);
    chk("hold_clr_tot", 64'(rpt_tot), 64'd40);
    chk("hold_clr_mask", 64'(fail_mask), 64'd0);
    rpt_req = 1'b0;
    step();
    chk("p40_release", 64'(rpt_ack), 64'd0);
    rpt_req = 1'b1;
    steps(2);
    chk("nochk_status", 64'(rpt_status), 64'd3);
    chk("nochk_tot",    64'(rpt_tot), 64'd0);
    rpt_req = 1'b0;
    step();

    // clr beats a same-cycle failing check.
    clr = 1'b1; die_en = 1'b1; chk_valid = 4'b1111; chk_pass = 4'b0000;
    step();
    clr = 1'b0; die_en = 1'b0; chk_valid = '0;
    chk("clrwin_mask", 64'(fail_mask), 64'd0);
    chk("clrwin_halt", 64'(halt), 64'd0);

    die_en = 1'b1; chk_valid = 4'b1000; chk_pass = 4'b0000;
    step();
    chk_valid = '0; die_en = 1'b0;
    chk("die_halt", 64'(halt), 64'd1);
    chk("die_ch",   64'(first_fail_ch), 64'd3);
    step();
    chk("die_hold", 64'(halt), 64'd1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("die_clr_halt", 64'(halt), 64'd0);
    chk("die_clr_mask", 64'(fail_mask), 64'd0);
    rpt_req = 1'b1;
    steps(2);
    chk("die_clr_tot",  64'(rpt_tot), 64'd0);
    chk("die_clr_fail", 64'(rpt_fail), 64'd0);
    rpt_req = 1'b0;
    step();

    // Saturation on the 4-bit instance.
    chk_valid = 4'b0001; chk_pass = 4'b0001;
    steps(20);
    chk_valid = '0;
    rpt_req = 1'b1;
    steps(2);
    chk("sat_pass",   64'(s_rpt_pass), 64'd15);
    chk("sat_tot",    64'(s_rpt_tot), 64'd15);
    chk("sat_status", 64'(s_rpt_status), 64'd1);
    chk("wide_pass",  64'(rpt_pass), 64'd20);
    rpt_req = 1'b0;
    step();
    chk_valid = 4'b0001; chk_pass = 4'b0000;
    step();
    chk_valid = '0;
    rpt_req = 1'b1;
    steps(2);
    chk("sat_fail",    64'(s_rpt_fail), 64'd1);
    chk("sat_tot2",    64'(s_rpt_tot), 64'd15);
    chk("sat_status2", 64'(s_rpt_status), 64'd2);
    chk("wide_tot",    64'(rpt_tot), 64'd21);

    // Reset in HOLD with rpt_req still high.
    chk("pre_rst_ack", 64'(rpt_ack), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("hold_rst_ack",    64'(rpt_ack), 64'd0);
    chk("hold_rst_status", 64'(rpt_status), 64'd0);
    chk("hold_rst_tot",    64'(rpt_tot), 64'd0);
    chk("hold_rst_fail",   64'(s_rpt_fail), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rerpt_ack0", 64'(rpt_ack), 64'd0);
    step();
    chk("rerpt_ack1",   64'(rpt_ack), 64'd1);
    chk("rerpt_status", 64'(rpt_status), 64'd3);
    rpt_req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
